corner_locator: RTL and testbench

- Streaming stage directly upstream of the image generator.
- Watches the camera pixel stream ({2'b0, R10, G10, B10}, 800x600 active) and classifies each pixel as marker / non-marker by colour threshold.
- Tracks the four extreme marker pixels of each frame.
- At frame end, issues one report pulse carrying UL/UR/DL/DR corner addresses in {row, col} form plus an enable flag. These drive the generator's addr_valid / enable / corner inputs.

---
 rtl/corner_pkg.sv | 48 ++++
 rtl/corner_locator_if.sv | 20 ++
 rtl/corner_locator_classifier.sv | 48 ++++
 rtl/corner_locator.sv | 194 +++++++++++++++++++
 tb/tb_corner_locator.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/corner_pkg.sv
// Shared types for the corner locator: pixel/coord layouts, FSM states,
// stage-1 bundle and the 11-bit key helpers used by the extreme trackers.
package corner_pkg;

  localparam int CW    = 10;
  localparam int SUM_W = 11;
  localparam int DIF_W = 11;
  localparam int CNT_W = 19;

  typedef struct packed {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } coord_t;

  typedef struct packed {
    logic [1:0]    pad;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    REPORT
  } state_t;

  typedef struct packed {
    logic   mark;
    coord_t pos;
  } s1_t;

  typedef logic [SUM_W-1:0]        sum_t;
  typedef logic signed [DIF_W-1:0] dif_t;

  function automatic sum_t pos_sum(coord_t p);
    return {1'b0, p.row} + {1'b0, p.col};
  endfunction

  function automatic dif_t pos_dif(
    logic [CW-1:0] a,
    logic [CW-1:0] b
  );
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

endpackage

// File: rtl/corner_locator_if.sv
// Camera pixel stream bundle: frame pulse, valid strobe and packed pixel.
interface corner_locator_if;

  logic        frame_start;
  logic        valid;
  logic [31:0] data;

  modport master (
    output frame_start,
    output valid,
    output data
  );

  modport slave (
    input frame_start,
    input valid,
    input data
  );

endinterface

// File: rtl/corner_locator_classifier.sv
// Stage 1: colour-threshold marker test, registered together with the
// raster coordinate of the accepted pixel.
module marker_classifier
  import corner_pkg::*;
#(
  parameter logic [CW-1:0] R_TH = 10'd600,
  parameter logic [CW-1:0] G_TH = 10'd300,
  parameter logic [CW-1:0] B_TH = 10'd300
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  corner_locator_if.slave   px,
  input  logic              accept_i,
  input  coord_t            pos_i,
  output logic              s1_vld_o,
  output s1_t               s1_o
);

  pixel_t pix;
  logic   mark;
  logic   unused_pad;
  logic   vld_q;
  s1_t    s1_q;
  s1_t    s1_d;

  assign pix        = pixel_t'(px.data);
  assign unused_pad = ^pix.pad;
  assign mark       = (pix.r >= R_TH)
                    && (pix.g < G_TH)
                    && (pix.b < B_TH);

  assign s1_d.mark = mark;
  assign s1_d.pos  = pos_i;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= 1'b0;
      s1_q  <= '0;
    end else begin
      vld_q <= accept_i;
      if (accept_i) s1_q <= s1_d;
    end
  end

  assign s1_vld_o = vld_q;
  assign s1_o     = s1_q;

endmodule

// File: rtl/corner_locator.sv
// Marker corner locator: tracks the four extreme marker pixels per frame
// and emits one registered corner report after the frame's last pixel.
module corner_locator
  import corner_pkg::*;
#(
  parameter int            H_ACT   = 800,
  parameter int            V_ACT   = 600,
  parameter logic [CW-1:0] R_TH    = 10'd600,
  parameter logic [CW-1:0] G_TH    = 10'd300,
  parameter logic [CW-1:0] B_TH    = 10'd300,
  parameter int            MIN_PIX = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_valid,
  input  logic [31:0]      i_data,
  output logic             o_addr_valid,
  output logic             o_enable,
  output logic [19:0]      o_ul_addr,
  output logic [19:0]      o_ur_addr,
  output logic [19:0]      o_dl_addr,
  output logic [19:0]      o_dr_addr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  localparam logic [CW-1:0] H_LAST = CW'(H_ACT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_ACT - 1);

  corner_locator_if pix ();

  assign pix.frame_start = i_frame_start;
  assign pix.valid       = i_valid;
  assign pix.data        = i_data;

  state_t            state_q;
  coord_t            pos_q;
  logic              fs;
  logic              accept;
  logic              last;
  logic              en_d;
  logic              hit;
  s1_t               s1;
  logic              s1_vld;
  sum_t              k_sum;
  dif_t              k_ur;
  dif_t              k_dl;

  logic [CNT_W-1:0]  cnt_q;
  coord_t            ul_q, ur_q, dl_q, dr_q;
  sum_t              ul_key_q, dr_key_q;
  dif_t              ur_key_q, dl_key_q;

  logic              av_q, en_q, busy_q;
  coord_t            rul_q, rur_q, rdl_q, rdr_q;
  logic [CNT_W-1:0]  rcnt_q;

  assign fs     = pix.frame_start;
  assign accept = (state_q == SCAN) && pix.valid && !fs;
  assign last   = (pos_q.row == V_LAST)
               && (pos_q.col == H_LAST);
  assign en_d   = cnt_q >= CNT_W'(MIN_PIX);

  marker_classifier #(
    .R_TH (R_TH),
    .G_TH (G_TH),
    .B_TH (B_TH)
  ) u_cls (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .px       (pix),
    .accept_i (accept),
    .pos_i    (pos_q),
    .s1_vld_o (s1_vld),
    .s1_o     (s1)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      busy_q  <= 1'b0;
      av_q    <= 1'b0;
      en_q    <= 1'b0;
      rcnt_q  <= '0;
      rul_q   <= '0;
      rur_q   <= '0;
      rdl_q   <= '0;
      rdr_q   <= '0;
    end else begin
      av_q <= 1'b0;
      if (fs) begin
        pos_q <= '0;
      end else if (accept) begin
        if (pos_q.col == H_LAST) begin
          pos_q.col <= '0;
          pos_q.row <= (pos_q.row == V_LAST) ? '0
                     : pos_q.row + 1'b1;
        end else begin
          pos_q.col <= pos_q.col + 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (fs) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (accept && last) state_q <= DRAIN;
        end
        DRAIN: begin
          state_q <= fs ? SCAN : REPORT;
          busy_q  <= fs;
        end
        REPORT: begin
          av_q   <= 1'b1;
          en_q   <= en_d;
          rcnt_q <= cnt_q;
          if (en_d) begin
            rul_q <= ul_q;
            rur_q <= ur_q;
            rdl_q <= dl_q;
            rdr_q <= dr_q;
          end
          state_q <= fs ? SCAN : IDLE;
          busy_q  <= fs;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 2: strict compares keep the earliest pixel on key ties.
  assign k_sum = pos_sum(s1.pos);
  assign k_ur  = pos_dif(s1.pos.col, s1.pos.row);
  assign k_dl  = pos_dif(s1.pos.row, s1.pos.col);
  assign hit   = s1_vld && s1.mark && !fs;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || fs) begin
      cnt_q    <= '0;
      ul_q     <= '0;
      ur_q     <= '0;
      dl_q     <= '0;
      dr_q     <= '0;
      ul_key_q <= '0;
      dr_key_q <= '0;
      ur_key_q <= '0;
      dl_key_q <= '0;
    end else if (hit) begin
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '0) begin
        ul_q     <= s1.pos;
        ur_q     <= s1.pos;
        dl_q     <= s1.pos;
        dr_q     <= s1.pos;
        ul_key_q <= k_sum;
        dr_key_q <= k_sum;
        ur_key_q <= k_ur;
        dl_key_q <= k_dl;
      end else begin
        if (k_sum < ul_key_q) begin
          ul_q     <= s1.pos;
          ul_key_q <= k_sum;
        end
        if (k_sum > dr_key_q) begin
          dr_q     <= s1.pos;
          dr_key_q <= k_sum;
        end
        if (k_ur > ur_key_q) begin
          ur_q     <= s1.pos;
          ur_key_q <= k_ur;
        end
        if (k_dl > dl_key_q) begin
          dl_q     <= s1.pos;
          dl_key_q <= k_dl;
        end
      end
    end
  end

  assign o_addr_valid = av_q;
  assign o_enable     = en_q;
  assign o_ul_addr    = rul_q;
  assign o_ur_addr    = rur_q;
  assign o_dl_addr    = rdl_q;
  assign o_dr_addr    = rdr_q;
  assign o_count      = rcnt_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_corner_locator.sv
// Directed bench for corner_locator on a reduced 80x60 raster; one
// instance uses the default marker floor, the other a floor of 4.
module tb_corner_locator;

  localparam int H = 80;
  localparam int V = 60;

  typedef struct {
    string       name;
    int          mode;
    bit          gaps;
    int          extra;
    int          sel;
    logic [19:0] ul, ur, dl, dr;
    logic        en;
    logic [18:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corner_locator_if pix ();

  logic        av   [2];
  logic        en   [2];
  logic        busy [2];
  logic [19:0] ul   [2];
  logic [19:0] ur   [2];
  logic [19:0] dl   [2];
  logic [19:0] dr   [2];
  logic [18:0] cnt  [2];

  corner_locator #(.H_ACT(H), .V_ACT(V)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_frame_start(pix.frame_start),
    .i_valid(pix.valid), .i_data(pix.data),
    .o_addr_valid(av[0]), .o_enable(en[0]),
    .o_ul_addr(ul[0]), .o_ur_addr(ur[0]),
    .o_dl_addr(dl[0]), .o_dr_addr(dr[0]),
    .o_count(cnt[0]), .o_busy(busy[0])
  );

  corner_locator #(.H_ACT(H), .V_ACT(V), .MIN_PIX(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_frame_start(pix.frame_start),
    .i_valid(pix.valid), .i_data(pix.data),
    .o_addr_valid(av[1]), .o_enable(en[1]),
    .o_ul_addr(ul[1]), .o_ur_addr(ur[1]),
    .o_dl_addr(dl[1]), .o_dr_addr(dr[1]),
    .o_count(cnt[1]), .o_busy(busy[1])
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;
  int rep_n [2] = '{0, 0};
  int rep_cyc [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (av[s] === 1'b1) begin
        rep_n[s]++;
        rep_cyc[s] = cyc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] rc(int r, int c);
    return {10'(r), 10'(c)};
  endfunction

  function automatic logic [31:0] pix_data(int mode, int r, int c);
    logic [31:0] red = {2'b0, 10'd1000, 10'd0, 10'd0};
    case (mode)
      0: return (r >= 10 && r <= 19 && c >= 30 && c <= 44) ? red : '0;
      1: return ((r == 5 && c == 40) || (r == 15 && c == 30) ||
                 (r == 15 && c == 50) || (r == 25 && c == 40)) ? red : '0;
      2: return (r == 2 && c < 10) ? red : '0;
      default: begin
        if (r == 0) begin
          case (c)
            0: return {2'b0, 10'd600, 10'd299, 10'd299};
            1: return {2'b0, 10'd599, 10'd0, 10'd0};
            2: return {2'b0, 10'd1000, 10'd300, 10'd0};
            3: return {2'b0, 10'd1000, 10'd0, 10'd300};
            4: return {2'b0, 10'd1023, 10'd0, 10'd0};
            default: return '0;
          endcase
        end
        return '0;
      end
    endcase
  endfunction

  task automatic send_frame(int mode, bit gaps, int abort_at,
                            int extra, bit start, bit chain);
    if (start) begin
      pix.frame_start = 1'b1;
      pix.valid = 1'b0;
      step();
      pix.frame_start = 1'b0;
    end
    for (int i = 0; i < H * V; i++) begin
      if (i == abort_at) begin
        pix.valid = 1'b0;
        return;
      end
      if (gaps) begin
        while ($urandom_range(1) == 0) begin
          pix.valid = 1'b0;
          pix.data = $urandom;
          step();
        end
      end
      pix.valid = 1'b1;
      pix.data = pix_data(mode, i / H, i % H);
      step();
      last_acc = cyc;
    end
    if (chain) begin
      pix.valid = 1'b0;
      step();
      pix.frame_start = 1'b1;
      step();
      pix.frame_start = 1'b0;
    end
    for (int e = 0; e < extra; e++) begin
      pix.valid = 1'b1;
      pix.data = {2'b0, 10'd1000, 20'd0};
      step();
    end
    pix.valid = 1'b0;
    repeat (6) step();
  endtask

  task automatic check_vec(vec_t v, int n0);
    int s = v.sel;
    chk({v.name, ".reports"}, rep_n[s] - n0, 1);
    chk({v.name, ".latency"}, rep_cyc[s] - last_acc, 2);
    chk({v.name, ".enable"}, 32'(en[s]), 32'(v.en));
    chk({v.name, ".count"}, 32'(cnt[s]), 32'(v.cnt));
    chk({v.name, ".ul"}, 32'(ul[s]), 32'(v.ul));
    chk({v.name, ".ur"}, 32'(ur[s]), 32'(v.ur));
    chk({v.name, ".dl"}, 32'(dl[s]), 32'(v.dl));
    chk({v.name, ".dr"}, 32'(dr[s]), 32'(v.dr));
  endtask

  vec_t vt [5];
  vec_t v_rect4;
  vec_t v_sparse;

  initial begin
    int n0;
    vt[0] = '{"rect", 0, 0, 0, 0, rc(10, 30), rc(10, 44),
              rc(19, 30), rc(19, 44), 1'b1, 19'd150};
    vt[1] = '{"sparse", 2, 0, 0, 0, rc(10, 30), rc(10, 44),
              rc(19, 30), rc(19, 44), 1'b0, 19'd10};
    vt[2] = '{"ties", 1, 0, 0, 1, rc(5, 40), rc(5, 40),
              rc(15, 30), rc(15, 50), 1'b1, 19'd4};
    vt[3] = '{"thresh", 3, 0, 0, 1, rc(5, 40), rc(5, 40),
              rc(15, 30), rc(15, 50), 1'b0, 19'd2};
    vt[4] = '{"gaps", 0, 1, 20, 0, rc(10, 30), rc(10, 44),
              rc(19, 30), rc(19, 44), 1'b1, 19'd150};
    v_rect4 = vt[0];
    v_rect4.name = "restart";
    v_rect4.sel = 1;
    v_sparse = vt[1];
    v_sparse.name = "chain2";

    pix.frame_start = 1'b0;
    pix.valid = 1'b0;
    pix.data = '0;
    repeat (3) begin
      pix.valid = ~pix.valid;
      pix.data = {2'b0, 10'd1000, 20'd0};
      step();
    end
    for (int s = 0; s < 2; s++) begin
      chk("rst.flags", {29'd0, av[s], en[s], busy[s]}, 0);
      chk("rst.ulur", {ul[s], 12'd0} | {ur[s], 12'd0}, 0);
      chk("rst.dldr", {dl[s], 12'd0} | {dr[s], 12'd0}, 0);
      chk("rst.count", 32'(cnt[s]), 0);
    end
    pix.valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle.busy", 32'(busy[0]), 0);
    chk("idle.reports", rep_n[0] + rep_n[1], 0);

    for (int k = 0; k < 5; k++) begin
      n0 = rep_n[vt[k].sel];
      send_frame(vt[k].mode, vt[k].gaps, -1, vt[k].extra, 1'b1, 1'b0);
      check_vec(vt[k], n0);
    end

    n0 = rep_n[1];
    send_frame(1, 1'b0, 2000, 0, 1'b1, 1'b0);
    chk("restart.busy", 32'(busy[1]), 1);
    send_frame(0, 1'b0, -1, 0, 1'b1, 1'b0);
    check_vec(v_rect4, n0);

    n0 = rep_n[0];
    send_frame(3, 1'b0, -1, 0, 1'b1, 1'b1);
    chk("chain.reports", rep_n[0] - n0, 1);
    chk("chain.busy", 32'(busy[0]), 1);
    n0 = rep_n[0];
    send_frame(2, 1'b0, -1, 0, 1'b0, 1'b0);
    check_vec(v_sparse, n0);

    n0 = rep_n[0];
    send_frame(0, 1'b0, 2000, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("midrst.reports", rep_n[0] - n0, 0);
    chk("midrst.busy", 32'(busy[0]), 0);
    chk("midrst.count", 32'(cnt[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
